led_id_sweeper: RTL and testbench

- Successor to the single-bit calibration ID display; drives per-LED colour in answer to the LED driver's request index.
- Shows one bit of each LED's address per frame as a colour, optionally followed by the complementary (inverted) frame for differential camera capture.
- Steps through bit positions manually (increment/decrement edges) or automatically (auto-sweep, fixed frames per bit).
- Flags frames that are safe for the camera to sample, after a configurable number of settle frames.

---
 rtl/led_id_sweeper.sv | 144 ++++++++++++++
 tb/tb_led_id_sweeper.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/led_id_sweeper.sv
// Per-LED address-bit colour display for camera-based LED identification.
// Steps through (bit, phase) pairs manually or automatically and flags settled frames.
module led_id_sweeper #(
  parameter int unsigned NUM_LEDS          = 50,
  parameter int unsigned LED_ADDRESS_WIDTH = 6,
  parameter int unsigned SETTLE_FRAMES     = 2,
  parameter int unsigned HOLD_FRAMES       = 4,
  parameter bit          DIFFERENTIAL      = 1'b1,
  parameter logic [23:0] COLOR_ZERO        = 24'hFF0000,
  parameter logic [23:0] COLOR_ONE         = 24'h0000FF,
  parameter logic [23:0] COLOR_ERR         = 24'h000000,
  localparam int unsigned NUM_BITS         = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1,
  localparam int unsigned BIT_IDX_W        = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         mode_auto,
  input  logic                         increment_bit,
  input  logic                         decrement_bit,
  input  logic [LED_ADDRESS_WIDTH-1:0] next_led_request,
  output logic [7:0]                   red_out,
  output logic [7:0]                   green_out,
  output logic [7:0]                   blue_out,
  output logic                         color_valid,
  output logic                         displayed_frame_valid,
  output logic [BIT_IDX_W-1:0]         bit_index,
  output logic                         phase_inverted,
  output logic                         sweep_done
);

  typedef enum logic [0:0] {StSettling, StValid} state_e;

  localparam logic [LED_ADDRESS_WIDTH:0] NumLedsW = (LED_ADDRESS_WIDTH + 1)'(NUM_LEDS);
  localparam logic [BIT_IDX_W-1:0]       LastBit  = BIT_IDX_W'(NUM_BITS - 1);
  localparam logic [15:0]                SettleW  = 16'(SETTLE_FRAMES);
  localparam logic [15:0]                HoldW    = 16'(HOLD_FRAMES);

  state_e                         state_q;
  logic                           inc_q, dec_q, mode_q;
  logic [LED_ADDRESS_WIDTH-1:0]   prev_request_q;
  logic [15:0]                    settle_cnt_q, hold_cnt_q;

  logic                           inc_rise, dec_rise, manual_step, cancel_step;
  logic                           frame_start, hold_done, auto_step, do_step, step_fwd;
  logic                           req_err, cur_bit, wrap;
  logic [BIT_IDX_W-1:0]           fwd_bit, bwd_bit;
  logic                           fwd_phase, bwd_phase;
  logic [23:0]                    color_d;

  always_comb begin
    inc_rise    = increment_bit & ~inc_q;
    dec_rise    = decrement_bit & ~dec_q;
    manual_step = inc_rise ^ dec_rise;
    cancel_step = inc_rise & dec_rise;
    frame_start = (next_led_request == '0) && (prev_request_q != '0);
    // A mode change in this cycle clears the hold count instead of advancing it.
    hold_done   = mode_auto && (mode_q == mode_auto) && (state_q == StValid) && frame_start &&
                  ((hold_cnt_q + 16'd1) == HoldW);
    auto_step   = ~inc_rise & ~dec_rise & hold_done;
    do_step     = manual_step | auto_step;
    step_fwd    = auto_step | inc_rise;
    wrap        = (bit_index == LastBit) && (phase_inverted || !DIFFERENTIAL);
  end

  always_comb begin
    fwd_bit   = bit_index;
    fwd_phase = 1'b0;
    if (DIFFERENTIAL && !phase_inverted) begin
      fwd_phase = 1'b1;
    end else begin
      fwd_bit = (bit_index == LastBit) ? '0 : bit_index + 1'b1;
    end
    bwd_bit   = bit_index;
    bwd_phase = 1'b0;
    if (!(DIFFERENTIAL && phase_inverted)) begin
      bwd_bit   = (bit_index == '0) ? LastBit : bit_index - 1'b1;
      bwd_phase = DIFFERENTIAL;
    end
  end

  always_comb begin
    req_err = {1'b0, next_led_request} >= NumLedsW;
    cur_bit = next_led_request[bit_index] ^ phase_inverted;
    if (req_err) begin
      color_d = COLOR_ERR;
    end else if (cur_bit) begin
      color_d = COLOR_ONE;
    end else begin
      color_d = COLOR_ZERO;
    end
  end

  always_ff @(posedge clk) begin
    // Edge detectors track the inputs even in reset so a held button causes no step.
    inc_q  <= increment_bit;
    dec_q  <= decrement_bit;
    mode_q <= mode_auto;
    if (rst) begin
      state_q               <= StSettling;
      prev_request_q        <= '0;
      settle_cnt_q          <= '0;
      hold_cnt_q            <= '0;
      red_out               <= '0;
      green_out             <= '0;
      blue_out              <= '0;
      color_valid           <= 1'b0;
      displayed_frame_valid <= 1'b0;
      bit_index             <= '0;
      phase_inverted        <= 1'b0;
      sweep_done            <= 1'b0;
    end else begin
      prev_request_q                 <= next_led_request;
      {red_out, green_out, blue_out} <= color_d;
      color_valid                    <= 1'b1;
      sweep_done                     <= auto_step & wrap;
      if (cancel_step) begin
        // Opposing edges together: leave everything as it is.
      end else if (do_step) begin
        bit_index             <= step_fwd ? fwd_bit : bwd_bit;
        phase_inverted        <= step_fwd ? fwd_phase : bwd_phase;
        settle_cnt_q          <= '0;
        hold_cnt_q            <= '0;
        state_q               <= StSettling;
        displayed_frame_valid <= 1'b0;
      end else if (state_q == StSettling) begin
        if (frame_start) begin
          if ((settle_cnt_q + 16'd1) == SettleW) begin
            settle_cnt_q          <= '0;
            state_q               <= StValid;
            displayed_frame_valid <= 1'b1;
          end else begin
            settle_cnt_q <= settle_cnt_q + 16'd1;
          end
        end
      end else if (mode_auto && frame_start) begin
        hold_cnt_q <= hold_cnt_q + 16'd1;
      end
      if (mode_q != mode_auto) begin
        hold_cnt_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_led_id_sweeper.sv
// Directed-plus-random bench for led_id_sweeper against a step-index reference model.
module tb_led_id_sweeper;

  localparam int NL     = 50;
  localparam int SETTLE = 2;
  localparam int HOLD   = 3;
  localparam int NSTEPS = 12;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mode_auto = 1'b0;
  logic       increment_bit = 1'b0;
  logic       decrement_bit = 1'b0;
  logic [5:0] req = '0;
  logic [7:0] red_out, green_out, blue_out;
  logic       color_valid, displayed_frame_valid, phase_inverted, sweep_done;
  logic [2:0] bit_index;

  led_id_sweeper #(
    .NUM_LEDS          (NL),
    .LED_ADDRESS_WIDTH (6),
    .SETTLE_FRAMES     (SETTLE),
    .HOLD_FRAMES       (HOLD),
    .DIFFERENTIAL      (1'b1)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .mode_auto             (mode_auto),
    .increment_bit         (increment_bit),
    .decrement_bit         (decrement_bit),
    .next_led_request      (req),
    .red_out               (red_out),
    .green_out             (green_out),
    .blue_out              (blue_out),
    .color_valid           (color_valid),
    .displayed_frame_valid (displayed_frame_valid),
    .bit_index             (bit_index),
    .phase_inverted        (phase_inverted),
    .sweep_done            (sweep_done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: the (bit, phase) pair is a single step number 0..11.
  int         m_step = 0, m_settle = 0, m_hold = 0;
  bit         m_valid = 0, m_cvalid = 0, m_done = 0;
  logic [5:0] m_prev = '0;
  bit         m_inc = 0, m_dec = 0, m_mode = 0;
  logic [23:0] m_color = '0;
  int         m_auto_steps = 0, m_done_count = 0, dut_done_count = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    bit ir, dr, fs;
    int b, ph;
    if (rst) begin
      m_step = 0; m_settle = 0; m_hold = 0; m_valid = 0;
      m_prev = '0; m_color = '0; m_cvalid = 0; m_done = 0;
    end else begin
      b  = m_step / 2;
      ph = m_step % 2;
      if (int'(req) >= NL) m_color = 24'h000000;
      else if ((((int'(req) >> b) & 1) ^ ph) != 0) m_color = 24'h0000FF;
      else m_color = 24'hFF0000;
      fs = (req == 0) && (m_prev != 0);
      ir = increment_bit && !m_inc;
      dr = decrement_bit && !m_dec;
      m_done = 0;
      if (ir && dr) begin
      end else if (ir || dr) begin
        m_step   = ir ? (m_step + 1) % NSTEPS : (m_step + NSTEPS - 1) % NSTEPS;
        m_settle = 0; m_hold = 0; m_valid = 0;
      end else if (!m_valid) begin
        if (fs) begin
          m_settle++;
          if (m_settle == SETTLE) begin
            m_valid  = 1;
            m_settle = 0;
          end
        end
      end else if (mode_auto && (mode_auto == m_mode) && fs) begin
        m_hold++;
        if (m_hold == HOLD) begin
          m_step  = (m_step + 1) % NSTEPS;
          m_done  = (m_step == 0);
          m_auto_steps++;
          m_hold  = 0;
          m_valid = 0;
        end
      end
      if (mode_auto != m_mode) m_hold = 0;
      if (m_done) m_done_count++;
      m_cvalid = 1;
      m_prev   = req;
    end
    m_inc  = increment_bit;
    m_dec  = decrement_bit;
    m_mode = mode_auto;
    @(posedge clk);
    #1;
    if (sweep_done) dut_done_count++;
    check("color", {8'h0, red_out, green_out, blue_out}, {8'h0, m_color});
    check("color_valid", 32'(color_valid), 32'(m_cvalid));
    check("frame_valid", 32'(displayed_frame_valid), 32'(m_valid));
    check("bit_index", 32'(bit_index), 32'(m_step / 2));
    check("phase", 32'(phase_inverted), 32'(m_step % 2));
    check("sweep_done", 32'(sweep_done), 32'(m_done));
  endtask

  task automatic frames(input int n, input int len, input bit rnd);
    for (int f = 0; f < n; f++) begin
      req = '0;
      tick();
      for (int i = 1; i < len; i++) begin
        req = rnd ? 6'($urandom_range(1, 63)) : 6'(i);
        tick();
      end
    end
  endtask

  task automatic pulse_inc();
    increment_bit = 1'b1;
    tick();
    increment_bit = 1'b0;
    tick();
  endtask

  initial begin
    bit coincide_done = 0;
    int step_before;
    int guard;

    // Reset
    for (int i = 0; i < 3; i++) tick();
    check("rst_color", {8'h0, red_out, green_out, blue_out}, 32'h0);
    check("rst_cvalid", 32'(color_valid), 32'h0);
    check("rst_bit", 32'(bit_index), 32'h0);

    // Colour path at (0,0)
    rst = 1'b0;
    req = 6'd5;
    tick();
    check("req5_blue", {8'h0, red_out, green_out, blue_out}, 32'h0000FF);
    req = 6'd4;
    tick();
    check("req4_red", {8'h0, red_out, green_out, blue_out}, 32'hFF0000);
    frames(3, NL, 1'b0);
    check("settled_after_2", 32'(displayed_frame_valid), 32'h1);
    req = 6'd50;
    tick();
    check("req50_err", {8'h0, red_out, green_out, blue_out}, 32'h0);
    req = 6'd63;
    tick();
    check("req63_err", {8'h0, red_out, green_out, blue_out}, 32'h0);
    check("req63_cvalid", 32'(color_valid), 32'h1);

    // Manual stepping through all 12 pairs
    for (int k = 1; k <= NSTEPS; k++) begin
      pulse_inc();
      check("man_valid_drop", 32'(displayed_frame_valid), 32'h0);
      check("man_bit", 32'(bit_index), 32'((k % NSTEPS) / 2));
      if (k == 1) begin
        req = 6'd5;
        tick();
        check("inv_req5_red", {8'h0, red_out, green_out, blue_out}, 32'hFF0000);
      end
      frames(3, 6, 1'b1);
      check("man_valid_rise", 32'(displayed_frame_valid), 32'h1);
    end

    // Backward wrap and cancelling edges
    decrement_bit = 1'b1;
    tick();
    decrement_bit = 1'b0;
    tick();
    check("dec_wrap_bit", 32'(bit_index), 32'd5);
    check("dec_wrap_phase", 32'(phase_inverted), 32'd1);
    frames(3, 6, 1'b1);
    increment_bit = 1'b1;
    decrement_bit = 1'b1;
    tick();
    increment_bit = 1'b0;
    decrement_bit = 1'b0;
    tick();
    check("cancel_bit", 32'(bit_index), 32'd5);
    check("cancel_valid", 32'(displayed_frame_valid), 32'h1);

    // Auto sweep with one manual edge landing on an auto step
    mode_auto = 1'b1;
    guard = 0;
    while (m_auto_steps < 14 && guard < 400) begin
      guard++;
      req = '0;
      if (!coincide_done && m_valid && m_hold == HOLD - 1 && m_prev != 0 && m_auto_steps > 2) begin
        step_before   = m_step;
        increment_bit = 1'b1;
        tick();
        increment_bit = 1'b0;
        coincide_done = 1;
        check("coincide_one_step", 32'(bit_index * 2 + phase_inverted),
              32'((step_before + 1) % NSTEPS));
      end else begin
        tick();
      end
      for (int i = 1; i < int'($urandom_range(2, 8)); i++) begin
        req = 6'($urandom_range(1, 63));
        tick();
      end
    end
    check("auto_budget", 32'(m_auto_steps >= 14), 32'h1);
    check("coincide_seen", 32'(coincide_done), 32'h1);
    check("sweep_done_count", 32'(dut_done_count), 32'(m_done_count));
    check("sweep_done_seen", 32'(dut_done_count >= 1), 32'h1);

    // Reset during (3,1) in auto mode, button held through reset
    guard = 0;
    while (m_step != 7 && guard < 200) begin
      guard++;
      frames(1, 4, 1'b1);
    end
    check("reached_3_1", 32'(m_step), 32'd7);
    increment_bit = 1'b1;
    rst = 1'b1;
    tick();
    check("midrst_bit", 32'(bit_index), 32'h0);
    check("midrst_phase", 32'(phase_inverted), 32'h0);
    check("midrst_color", {8'h0, red_out, green_out, blue_out}, 32'h0);
    tick();
    rst = 1'b0;
    tick();
    tick();
    frames(2, 5, 1'b1);
    check("held_no_step_bit", 32'(bit_index), 32'h0);
    check("held_no_step_phase", 32'(phase_inverted), 32'h0);
    increment_bit = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
